// File: rtl/signal_tracker_arb_pkg.sv
// Shared types for the tracker query arbiter: FSM states, result status codes and the result record.
package signal_tracker_arb_pkg;

  localparam int TIME_W = 32;

  typedef logic signed [TIME_W-1:0] time_t;

  localparam time_t NO_TIME = -32'sd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    STAT_OK        = 3'd0,
    STAT_OPEN      = 3'd1,
    STAT_NOT_FOUND = 3'd2,
    STAT_EXPIRED   = 3'd3,
    STAT_TIMEOUT   = 3'd4
  } status_e;

  typedef struct packed {
    status_e status;
    time_t   start_time;
    time_t   end_time;
  } result_t;

  localparam result_t RESULT_NONE = '{status: STAT_OK, start_time: NO_TIME, end_time: NO_TIME};

  // A negative start means no activity; a negative end means activity is still ongoing.
  function automatic status_e classify(input time_t s, input time_t e);
    if (s < 0) return STAT_NOT_FOUND;
    if (e < 0) return STAT_OPEN;
    return STAT_OK;
  endfunction

endpackage

// File: rtl/signal_tracker_query_arbiter_rr.sv
// Combinational round-robin picker: one-hot grant to the first requester at or after ptr.
// Zero latency; the owner decides when the pointer advances.
module round_robin_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signal_tracker_query_arbiter.sv
// Shares one activity tracker between NUM_REQ requesters; 4-cycle nominal accept-to-response, one query in flight.
// Requests are held by the requester until req_ready; responses are single-cycle pulses with no backpressure.
module signal_tracker_query_arbiter
  import signal_tracker_arb_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BUFFER_WIDTH  = 8,
  parameter int COUNTER_WIDTH = 32,
  parameter int WAIT_LIMIT    = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [COUNTER_WIDTH-1:0]               counter,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][COUNTER_WIDTH-1:0]  req_window_start,
  output logic [NUM_REQ-1:0]                     req_ready,
  output logic [NUM_REQ-1:0]                     resp_valid,
  output logic [2:0]                             resp_status,
  output logic signed [31:0]                     resp_start,
  output logic signed [31:0]                     resp_end,
  output logic                                   trk_recalculate_time,
  output logic [31:0]                            trk_value_in,
  input  logic                                   trk_data_valid,
  input  logic signed [31:0]                     trk_time_out_start,
  input  logic signed [31:0]                     trk_time_out_end
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int WCW = $clog2(WAIT_LIMIT) + 1;
  localparam logic [COUNTER_WIDTH-1:0] BW_LIMIT  = COUNTER_WIDTH'(BUFFER_WIDTH);
  localparam logic [WCW-1:0]           WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  state_e                   state_q, state_d;
  logic [IDW-1:0]           ptr_q, ptr_d;
  logic [IDW-1:0]           id_q, id_d;
  logic [COUNTER_WIDTH-1:0] win_start_q, win_start_d;
  logic [WCW-1:0]           wait_cnt_q, wait_cnt_d;
  result_t                  result_q, result_d;
  logic                     recalc_q, recalc_d;

  logic [NUM_REQ-1:0]       grant;
  logic [IDW-1:0]           win_id;
  logic [COUNTER_WIDTH-1:0] diff;
  logic                     accept;

  round_robin_arbiter #(.N(NUM_REQ)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_id = IDW'(i);
    end
  end

  // A stale data_valid from the tracker must drain before a new query may start.
  assign req_ready = (state_q == ST_IDLE && !trk_data_valid) ? grant : '0;
  assign accept    = |req_ready;

  // Modulo subtract: a future window start wraps to a huge value and reads as expired.
  assign diff         = counter - win_start_q;
  assign trk_value_in = (state_q == ST_WAIT) ? 32'(diff) : 32'd0;

  assign resp_valid           = (state_q == ST_RESP) ? (NUM_REQ'(1) << id_q) : '0;
  assign resp_status          = result_q.status;
  assign resp_start           = result_q.start_time;
  assign resp_end             = result_q.end_time;
  assign trk_recalculate_time = recalc_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    win_start_d = win_start_q;
    wait_cnt_d  = wait_cnt_q;
    result_d    = result_q;
    recalc_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d        = win_id;
          win_start_d = req_window_start[win_id];
          ptr_d       = (win_id == IDW'(NUM_REQ - 1)) ? '0 : win_id + IDW'(1);
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (diff == '0 || diff > BW_LIMIT) begin
          result_d = '{status: STAT_EXPIRED, start_time: NO_TIME, end_time: NO_TIME};
          state_d  = ST_RESP;
        end else begin
          wait_cnt_d = '0;
          recalc_d   = 1'b1;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (trk_data_valid) begin
          result_d = '{status:     classify(trk_time_out_start, trk_time_out_end),
                       start_time: trk_time_out_start,
                       end_time:   trk_time_out_end};
          state_d  = ST_RESP;
        end else if (diff > BW_LIMIT) begin
          result_d = '{status: STAT_EXPIRED, start_time: NO_TIME, end_time: NO_TIME};
          state_d  = ST_RESP;
        end else if (wait_cnt_q == WAIT_LAST) begin
          result_d = '{status: STAT_TIMEOUT, start_time: NO_TIME, end_time: NO_TIME};
          state_d  = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
          recalc_d   = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      win_start_q <= '0;
      wait_cnt_q  <= '0;
      result_q    <= RESULT_NONE;
      recalc_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      win_start_q <= win_start_d;
      wait_cnt_q  <= wait_cnt_d;
      result_q    <= result_d;
      recalc_q    <= recalc_d;
    end
  end

endmodule

// File: tb/tb_signal_tracker_query_arbiter.sv
// Directed and randomized bench for signal_tracker_query_arbiter with a stub tracker and a
// query-level reference model (fair rotation, window age rules, stub answer timing).
module tb_signal_tracker_query_arbiter;
  import signal_tracker_arb_pkg::*;

  localparam int NR = 4;
  localparam int BW = 8;
  localparam int WL = 8;

  logic               clk;
  logic               rst;
  logic [31:0]        counter;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0][31:0] req_ws;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      resp_valid;
  logic [2:0]         resp_status;
  logic signed [31:0] resp_start;
  logic signed [31:0] resp_end;
  logic               trk_recalculate_time;
  logic [31:0]        trk_value_in;
  logic               stub_dv;
  logic signed [31:0] stub_s;
  logic signed [31:0] stub_e;

  int     stub_mode;   // 0: answers one cycle after recalc, 1: never answers, 2: data_valid stuck high
  bit     cnt_run;
  bit     refill;
  logic [NR-1:0] pending;
  int     mptr;
  int     errors;
  int     checks;

  signal_tracker_query_arbiter #(
    .NUM_REQ(NR), .BUFFER_WIDTH(BW), .COUNTER_WIDTH(32), .WAIT_LIMIT(WL)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .counter              (counter),
    .req_valid            (req_valid),
    .req_window_start     (req_ws),
    .req_ready            (req_ready),
    .resp_valid           (resp_valid),
    .resp_status          (resp_status),
    .resp_start           (resp_start),
    .resp_end             (resp_end),
    .trk_recalculate_time (trk_recalculate_time),
    .trk_value_in         (trk_value_in),
    .trk_data_valid       (stub_dv),
    .trk_time_out_start   (stub_s),
    .trk_time_out_end     (stub_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) stub_dv <= 1'b0;
    else if (stub_mode == 2) stub_dv <= 1'b1;
    else if (stub_mode == 1) stub_dv <= 1'b0;
    else stub_dv <= trk_recalculate_time & ~stub_dv;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cnt_run) counter = counter + 32'd1;
  endtask

  // Expected outcome of one query, from the window age seen at each cycle after acceptance.
  function automatic void model(input logic [31:0] wstart, input logic [31:0] cacc, input bit run,
                                input int mode, input logic signed [31:0] s, input logic signed [31:0] e,
                                output logic [2:0] st, output logic signed [31:0] os,
                                output logic signed [31:0] oe, output int lat, output bit rc);
    logic [31:0] age;
    logic [31:0] age_k;
    age = cacc + (run ? 32'd1 : 32'd0) - wstart;
    st = STAT_TIMEOUT; os = -1; oe = -1; lat = WL + 2; rc = 1'b0;
    if (age == 32'd0 || age > 32'(BW)) begin
      st = STAT_EXPIRED; lat = 2;
      return;
    end
    rc = 1'b1;
    for (int k = 0; k < WL; k++) begin
      age_k = age + (run ? 32'(k + 1) : 32'd0);
      if (mode == 0 && k == 1) begin
        os = s; oe = e; lat = 3 + k;
        st = (s < 0) ? STAT_NOT_FOUND : (e < 0) ? STAT_OPEN : STAT_OK;
        return;
      end
      if (age_k > 32'(BW)) begin
        st = STAT_EXPIRED; lat = 3 + k;
        return;
      end
    end
  endfunction

  task automatic run_query(input string tag);
    int exp_id, lat, exp_lat;
    logic [31:0] wsv, cacc;
    logic [2:0] est;
    logic signed [31:0] es, ee;
    bit erc, seen_rc, got;
    logic [NR-1:0] g;
    step();
    req_valid = pending;
    got = 1'b0;
    g = '0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      g = req_ready & req_valid;
      if (g != '0) begin got = 1'b1; break; end
      step();
      req_valid = pending;
    end
    chk({tag, "/accept"}, {31'd0, got}, 32'd1);
    if (!got) return;
    exp_id = mptr;
    for (int k = 0; k < NR; k++) begin
      if (pending[(mptr + k) % NR]) begin exp_id = (mptr + k) % NR; break; end
    end
    chk({tag, "/grant"}, {28'd0, g}, 32'(1 << exp_id));
    mptr = (exp_id + 1) % NR;
    wsv  = req_ws[exp_id];
    cacc = counter;
    model(wsv, cacc, cnt_run, stub_mode, stub_s, stub_e, est, es, ee, exp_lat, erc);
    seen_rc = 1'b0;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (n == 1) begin
        pending[exp_id] = 1'b0;
        if (refill) begin
          pending[exp_id] = 1'b1;
          req_ws[exp_id]  = counter - 32'd2;
        end
      end
      req_valid = pending;
      @(negedge clk);
      if (resp_valid != '0) begin lat = n; break; end
      if (trk_recalculate_time) begin
        seen_rc = 1'b1;
        chk({tag, "/value_in"}, trk_value_in, counter - wsv);
      end else begin
        chk({tag, "/value_idle"}, trk_value_in, 32'd0);
      end
    end
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/resp_valid"}, {28'd0, resp_valid}, 32'(1 << exp_id));
    chk({tag, "/status"}, {29'd0, resp_status}, {29'd0, est});
    chk({tag, "/start"}, resp_start, es);
    chk({tag, "/end"}, resp_end, ee);
    chk({tag, "/recalc_in_resp"}, {31'd0, trk_recalculate_time}, 32'd0);
    chk({tag, "/recalc_seen"}, {31'd0, seen_rc}, {31'd0, erc});
  endtask

  initial begin
    bit got;
    int r;
    errors = 0; checks = 0; mptr = 0;
    rst = 1'b1; counter = 32'd1000; cnt_run = 1'b1; refill = 1'b0;
    req_valid = '0; req_ws = '0; pending = '0;
    stub_mode = 0; stub_s = 32'sd10; stub_e = 32'sd20;
    repeat (3) step();
    @(negedge clk);
    chk("rst/req_ready", {28'd0, req_ready}, 32'd0);
    chk("rst/resp_valid", {28'd0, resp_valid}, 32'd0);
    chk("rst/status", {29'd0, resp_status}, 32'd0);
    chk("rst/start", resp_start, 32'hFFFF_FFFF);
    chk("rst/end", resp_end, 32'hFFFF_FFFF);
    chk("rst/recalc", {31'd0, trk_recalculate_time}, 32'd0);
    chk("rst/value_in", trk_value_in, 32'd0);
    step();
    rst = 1'b0;

    // Every requester kept valid: grants rotate 0,1,2,3,0.
    refill = 1'b1;
    pending = 4'b1111;
    for (int i = 0; i < NR; i++) req_ws[i] = counter - 32'd2;
    for (int q = 0; q < 5; q++) run_query("rr");
    refill = 1'b0;
    for (int q = 0; q < 4; q++) run_query("drain");

    // Nominal path with a frozen counter.
    cnt_run = 1'b0;
    counter = 32'd100;
    pending = 4'b0010; req_ws[1] = 32'd96;
    stub_s = 32'sd97; stub_e = 32'sd98;
    run_query("nominal");

    // Window age limits.
    pending = 4'b0001; req_ws[0] = counter;
    run_query("age_zero");
    pending = 4'b1000; req_ws[3] = counter - 32'd9;
    run_query("age_over");
    pending = 4'b0100; req_ws[2] = counter - 32'd8;
    run_query("age_max");

    // Classification and timeout.
    stub_s = -32'sd1; stub_e = -32'sd1;
    pending = 4'b0010; req_ws[1] = counter - 32'd3;
    run_query("not_found");
    stub_s = 32'sd50; stub_e = -32'sd1;
    pending = 4'b0001; req_ws[0] = counter - 32'd5;
    run_query("open");
    stub_mode = 1;
    pending = 4'b1000; req_ws[3] = counter - 32'd4;
    run_query("timeout");
    stub_mode = 0;
    cnt_run = 1'b1;

    // Stale data_valid blocks acceptance.
    step();
    stub_mode = 2;
    step();
    step();
    req_valid = 4'b0001; req_ws[0] = counter - 32'd2;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("stale/req_ready", {28'd0, req_ready}, 32'd0);
      step();
    end
    req_valid = '0;
    stub_mode = 0;
    step();
    step();

    // Reset while waiting on the tracker drops the query.
    stub_mode = 1;
    req_ws[2] = counter - 32'd3;
    step();
    req_valid = 4'b0100;
    got = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (req_ready[2]) begin got = 1'b1; break; end
      step();
    end
    chk("rstq/accept", {31'd0, got}, 32'd1);
    step();
    req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (trk_recalculate_time) begin got = 1'b1; break; end
      step();
    end
    chk("rstq/in_wait", {31'd0, got}, 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rstq/recalc", {31'd0, trk_recalculate_time}, 32'd0);
    chk("rstq/value_in", trk_value_in, 32'd0);
    chk("rstq/resp_start", resp_start, 32'hFFFF_FFFF);
    for (int n = 0; n < 3; n++) begin
      chk("rstq/resp_valid", {28'd0, resp_valid}, 32'd0);
      step();
      @(negedge clk);
    end
    mptr = 0;
    stub_mode = 0; stub_s = 32'sd7; stub_e = 32'sd9;
    pending = 4'b1111;
    for (int i = 0; i < NR; i++) req_ws[i] = counter - 32'd3;
    run_query("rstq/ptr");
    for (int q = 0; q < 3; q++) run_query("rstq/drain");

    // Randomized traffic.
    for (int q = 0; q < 16; q++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          pending[i] = 1'b1;
          r = int'($urandom_range(0, 11));
          req_ws[i] = (r == 11) ? counter + 32'd5 : counter - 32'(r);
        end
      end
      if (pending == '0) begin
        pending[0] = 1'b1;
        req_ws[0] = counter - 32'd1;
      end
      stub_mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
      stub_s = ($urandom_range(0, 2) == 0) ? -32'sd1 : 32'($urandom_range(0, 200));
      stub_e = ($urandom_range(0, 2) == 0) ? -32'sd1 : 32'($urandom_range(0, 200));
      run_query("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
